// File: rtl/geno_array_scheduler.sv
// geno_array_scheduler: round-robin job dispatch to parallel genotyping arrays and arbitrated result collection
module geno_array_scheduler #(
  parameter int NUM_ARRAYS = 4,
  parameter int ID_W = 8,
  parameter int SCORE_W = 16,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(NUM_ARRAYS),
  localparam int IW = $clog2(NUM_ARRAYS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_job_valid,
  output logic                          o_job_ready,
  output logic [NUM_ARRAYS-1:0]         o_arr_valid,
  input  logic [NUM_ARRAYS-1:0]         i_arr_ready,
  output logic [AW-1:0]                 o_job_array,
  input  logic [NUM_ARRAYS-1:0]         i_res_valid,
  output logic [NUM_ARRAYS-1:0]         o_res_ready,
  input  logic [NUM_ARRAYS*SCORE_W-1:0] i_res_score,
  input  logic [NUM_ARRAYS*ID_W-1:0]    i_res_id,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic signed [SCORE_W-1:0]     o_res_score,
  output logic [ID_W-1:0]               o_res_id,
  output logic [AW-1:0]                 o_res_array,
  input  logic                          i_flush,
  output logic                          o_drained,
  output logic [IW-1:0]                 o_inflight,
  output logic [CNT_W-1:0]              o_jobs_done
);
  logic [NUM_ARRAYS-1:0] busy, disp_oh;
  logic [AW-1:0] disp_ptr, col_ptr, sel;
  logic [AW:0] disp_pick, col_pick;
  logic disp_hs, col_any, load, cap;

  // returns {found, index} of the first request at or after ptr, wrapping
  function automatic logic [AW:0] rr_pick(input logic [NUM_ARRAYS-1:0] req, input logic [AW-1:0] ptr);
    logic [AW:0] s;
    rr_pick = '0;
    for (int i = NUM_ARRAYS - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (AW+1)'(i);
      s = (s >= (AW+1)'(NUM_ARRAYS)) ? s - (AW+1)'(NUM_ARRAYS) : s;
      if (req[s[AW-1:0]]) rr_pick = {1'b1, s[AW-1:0]};
    end
  endfunction

  assign disp_pick   = rr_pick(i_arr_ready & ~busy, disp_ptr);
  assign col_pick    = rr_pick(i_res_valid & busy, col_ptr);
  assign o_job_ready = ~i_flush & disp_pick[AW];
  assign o_job_array = disp_pick[AW-1:0];
  assign disp_hs     = i_job_valid & o_job_ready;
  assign disp_oh     = disp_hs ? NUM_ARRAYS'(1) << o_job_array : '0;
  assign o_arr_valid = disp_oh;
  assign col_any     = col_pick[AW];
  assign sel         = col_pick[AW-1:0];
  assign load        = ~o_res_valid | i_res_ready;
  assign cap         = load & col_any;
  assign o_res_ready = cap ? NUM_ARRAYS'(1) << sel : '0;
  assign o_inflight  = IW'($countones(busy));
  assign o_drained   = (busy == '0) & ~o_res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      disp_ptr    <= '0;
      col_ptr     <= '0;
      o_res_valid <= 1'b0;
      o_res_score <= '0;
      o_res_id    <= '0;
      o_res_array <= '0;
      o_jobs_done <= '0;
    end else begin
      busy <= (busy | disp_oh) & ~o_res_ready;
      if (disp_hs) disp_ptr <= (o_job_array == AW'(NUM_ARRAYS - 1)) ? '0 : o_job_array + 1'b1;
      if (cap) begin
        col_ptr     <= (sel == AW'(NUM_ARRAYS - 1)) ? '0 : sel + 1'b1;
        o_res_valid <= 1'b1;
        o_res_score <= i_res_score[sel*SCORE_W +: SCORE_W];
        o_res_id    <= i_res_id[sel*ID_W +: ID_W];
        o_res_array <= sel;
      end else if (load) o_res_valid <= 1'b0;
      if (o_res_valid & i_res_ready) o_jobs_done <= o_jobs_done + 1'b1;
    end
  end
endmodule

// File: tb/tb_geno_array_scheduler.sv
// tb_geno_array_scheduler: directed plan scenarios then randomized traffic against a behavioural model
module tb_geno_array_scheduler;
  logic clk = 1'b0, rst_n;
  logic job_valid, flush, res_ready;
  logic [3:0] arr_ready, res_valid;
  logic [63:0] res_score;
  logic [31:0] res_id;
  logic job_ready, o_valid, drained;
  logic [3:0] arr_valid, res_ready_o;
  logic [1:0] job_array, o_arr;
  logic [15:0] o_score, jobs_done;
  logic [7:0] o_id;
  logic [2:0] inflight;

  geno_array_scheduler #(.NUM_ARRAYS(4), .ID_W(8), .SCORE_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_job_valid(job_valid), .o_job_ready(job_ready),
    .o_arr_valid(arr_valid), .i_arr_ready(arr_ready), .o_job_array(job_array),
    .i_res_valid(res_valid), .o_res_ready(res_ready_o), .i_res_score(res_score),
    .i_res_id(res_id), .o_res_valid(o_valid), .i_res_ready(res_ready),
    .o_res_score(o_score), .o_res_id(o_id), .o_res_array(o_arr), .i_flush(flush),
    .o_drained(drained), .o_inflight(inflight), .o_jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit [3:0] m_busy;
  int m_dptr, m_cptr, m_arr, e_g, e_s;
  bit m_ov, e_hs, e_cap, e_load;
  logic [15:0] m_score, m_done;
  logic [7:0] m_id;
  bit [3:0] hold;
  int cnt[4];
  logic [15:0] a_score[4];
  logic [7:0] a_id[4];
  logic [7:0] next_id = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_from(input bit [3:0] req, input int p);
    for (int i = 0; i < 4; i++) if (req[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic mreset();
    m_busy = '0; m_dptr = 0; m_cptr = 0; m_ov = 0;
    m_score = '0; m_id = '0; m_arr = 0; m_done = '0;
  endtask

  // compare every DUT output against the model, mid-cycle
  task automatic sample();
    @(negedge clk);
    e_g = first_from(arr_ready & ~m_busy, m_dptr);
    e_hs = job_valid && !flush && e_g >= 0;
    e_load = !m_ov || res_ready;
    e_s = first_from(res_valid & m_busy, m_cptr);
    e_cap = e_load && e_s >= 0;
    chk("job_ready", job_ready, 32'(!flush && e_g >= 0));
    chk("arr_valid", arr_valid, e_hs ? 1 << e_g : 0);
    if (e_hs) chk("job_array", job_array, e_g);
    chk("res_ready", res_ready_o, e_cap ? 1 << e_s : 0);
    chk("res_valid", o_valid, m_ov);
    chk("res_score", o_score, m_score);
    chk("res_id", o_id, m_id);
    chk("res_array", o_arr, m_arr);
    chk("inflight", inflight, $countones(m_busy));
    chk("jobs_done", jobs_done, m_done);
    chk("drained", drained, 32'(m_busy == 0 && !m_ov));
  endtask

  task automatic adv();
    if (m_ov && res_ready) m_done++;
    if (e_cap) begin
      m_busy[e_s] = 0; m_cptr = (e_s + 1) % 4; m_ov = 1; m_arr = e_s;
      m_score = res_score[e_s*16 +: 16]; m_id = res_id[e_s*8 +: 8];
    end else if (e_load) m_ov = 0;
    if (e_hs) begin m_busy[e_g] = 1; m_dptr = (e_g + 1) % 4; end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; job_valid = 0; flush = 0; res_ready = 0;
    arr_ready = '0; res_valid = '0; res_score = '0; res_id = '0;
    mreset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    sample();
    chk("rst_drained", drained, 1); chk("rst_inflight", inflight, 0);
    chk("rst_res_valid", o_valid, 0); chk("rst_jobs_done", jobs_done, 0);
    adv();
    // four back-to-back jobs then a full stall
    arr_ready = 4'hF; job_valid = 1; res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sample(); chk("t1_onehot", arr_valid, 1 << i); adv();
    end
    sample(); chk("t1_full_ready", job_ready, 0); chk("t1_inflight", inflight, 4); adv();
    job_valid = 0;
    // arrays 1 and 3 finish together
    res_score = {16'd200, 16'd0, 16'hFFFB, 16'd0};
    res_id = {8'd13, 8'd0, 8'd11, 8'd0};
    res_valid = 4'b1010;
    sample(); chk("t2_ack1", res_ready_o, 4'b0010); adv();
    res_valid = 4'b1000;
    sample(); chk("t2_score1", o_score, 16'hFFFB); chk("t2_arr1", o_arr, 1); adv();
    res_valid = 4'b0000;
    sample(); chk("t2_score3", o_score, 16'd200); chk("t2_arr3", o_arr, 3); adv();
    sample(); chk("t2_done", jobs_done, 2); chk("t2_inflight", inflight, 2); adv();
    // downstream stall holds the output and blocks other arrays
    res_score[15:0] = 16'd77; res_valid = 4'b0001; res_ready = 0;
    sample(); adv();
    res_valid = 4'b0100; res_score[47:32] = 16'd9;
    for (int i = 0; i < 5; i++) begin
      sample(); chk("t3_hold", o_score, 16'd77); chk("t3_noack", res_ready_o, 0); adv();
    end
    res_ready = 1;
    sample(); chk("t3_ack2", res_ready_o, 4'b0100); adv();
    res_valid = 0;
    sample(); adv();
    sample(); adv();
    // flush with three jobs in flight
    job_valid = 1; arr_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin sample(); adv(); end
    flush = 1; res_valid = 4'b0001;
    sample(); chk("t4_blocked", job_ready, 0); adv();
    res_valid = 4'b0010; sample(); adv();
    res_valid = 4'b0100; sample(); adv();
    res_valid = 4'b0000;
    sample(); chk("t4_not_drained", drained, 0); chk("t4_last_valid", o_valid, 1); adv();
    sample(); chk("t4_drained", drained, 1); adv();
    flush = 0;
    // grant wraps from pointer 3 to array 2
    arr_ready = 4'b0100;
    sample(); chk("t5_wrap", job_array, 2); adv();
    arr_ready = 4'hF;
    sample(); chk("t5_ptr3", job_array, 3); adv();
    // asynchronous reset with a result pending
    res_valid = 4'b0100; res_ready = 0; arr_ready = 4'b0001;
    sample(); adv();
    job_valid = 0; res_valid = 0;
    sample(); chk("t6_pre_valid", o_valid, 1); chk("t6_pre_inflight", inflight, 2);
    #2 rst_n = 0;
    #1;
    chk("t6_valid", o_valid, 0); chk("t6_inflight", inflight, 0); chk("t6_drained", drained, 1);
    mreset();
    @(posedge clk); #1 rst_n = 1;
    hold = '0;
    // randomized traffic with the bench acting as the arrays
    for (int c = 0; c < 3000; c++) begin
      job_valid = ($urandom % 4) != 0;
      flush = (c % 400) >= 330;
      res_ready = ($urandom % 4) != 0;
      for (int k = 0; k < 4; k++) begin
        arr_ready[k] = ($urandom % 4) != 0;
        if (hold[k]) begin
          res_valid[k] = cnt[k] == 0;
          res_score[k*16 +: 16] = a_score[k];
          res_id[k*8 +: 8] = a_id[k];
        end else begin
          res_valid[k] = ($urandom % 8) == 0;
          res_score[k*16 +: 16] = 16'($urandom);
          res_id[k*8 +: 8] = 8'($urandom);
        end
      end
      sample();
      if (e_cap) hold[e_s] = 0;
      for (int k = 0; k < 4; k++) if (hold[k] && cnt[k] > 0) cnt[k]--;
      if (e_hs) begin
        hold[e_g] = 1; cnt[e_g] = $urandom % 6;
        a_score[e_g] = 16'($urandom); a_id[e_g] = next_id; next_id++;
      end
      adv();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
